tm1638_spi: RTL and testbench

- Bit-serial master for a TM1638 LED/key controller on a 3-wire bus: STB, CLK and bidirectional DIO.
- Accepts one 18-bit transaction descriptor per handshake. A descriptor is a command-only write, an addressed data write, or a command followed by a 64-bit read.
- Sits between the display/key controller FSM and the chip pins.
- Exposes diagnostic taps for its state, the latched descriptor and the current address/byte index.

---
 rtl/tm1638_spi_if.sv | 33 +++
 rtl/tm1638_spi.sv | 197 +++++++++++++++++++
 tb/tb_tm1638_spi.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/tm1638_spi_if.sv
// tm1638_spi_if: request/response, pin and diagnostic signals of the TM1638
// bit-serial master, bundled for connection between the controller FSM
// (master side) and the serial engine (slave side).
//   i_Data_Ready / i_Data   : descriptor handshake into the engine
//   o_Busy                  : transaction in progress
//   o_Data_Valid / o_Data   : 64-bit read result and its completion pulse
//   o_SPI_Stb / o_SPI_Clk   : chip strobe (active low) and serial clock
//   o_Diag_*                : FSM state, latched descriptor, address/byte index
// DIO is bidirectional and stays a plain inout port on the engine.
interface tm1638_spi_if;
  logic        i_Data_Ready;
  logic [17:0] i_Data;
  logic        o_Busy;
  logic        o_Data_Valid;
  logic [63:0] o_Data;
  logic        o_SPI_Stb;
  logic        o_SPI_Clk;
  logic [2:0]  o_Diag_State;
  logic [17:0] o_Diag_Data;
  logic [3:0]  o_Diag_Addr;

  modport master (
    output i_Data_Ready, i_Data,
    input  o_Busy, o_Data_Valid, o_Data, o_SPI_Stb, o_SPI_Clk,
           o_Diag_State, o_Diag_Data, o_Diag_Addr
  );

  modport slave (
    input  i_Data_Ready, i_Data,
    output o_Busy, o_Data_Valid, o_Data, o_SPI_Stb, o_SPI_Clk,
           o_Diag_State, o_Diag_Data, o_Diag_Addr
  );
endinterface

// File: rtl/tm1638_spi.sv
// tm1638_spi: bit-serial master for a TM1638 on STB/CLK/DIO.
// One 18-bit descriptor per handshake:
//   [17:16] opcode  00/11 command byte, 01 addressed write, 10 command + 64-bit read
//   [11:8]  address (opcode 01)
//   [7:0]   command / data byte
// Ports:
//   i_Clk, i_Rst : system clock, async active-high reset
//   bus          : handshake, read result, STB/CLK pins, diagnostics
//   io_SPI_Dio   : bidirectional serial data, LSB first
// One bit time is 2*CYCLES clocks (CLK low CYCLES, then high CYCLES).
module tm1638_spi #(
  parameter int CYCLES = 4
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  tm1638_spi_if.slave bus,
  inout  wire         io_SPI_Dio
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_TURN  = 3'd3;
  localparam logic [2:0] S_RECV  = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;
  localparam logic [2:0] S_HOLD  = 3'd6;

  localparam int            CW    = $clog2(4*CYCLES + 1);
  localparam logic [CW-1:0] C1_M1 = CW'(CYCLES - 1);
  localparam logic [CW-1:0] C2_M1 = CW'(2*CYCLES - 1);
  localparam logic [CW-1:0] C4_M1 = CW'(4*CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    bit_q, bit_d;
  logic [15:0]   tx_q, tx_d;
  logic [17:0]   desc_q, desc_d;
  logic [63:0]   rx_q, rx_d;
  logic [63:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic          stb_q, stb_d;
  logic          sclk_q, sclk_d;
  logic          dio_q, dio_d;
  logic          oe_q, oe_d;

  logic [1:0] op;
  logic [6:0] last_bit;
  assign op       = desc_q[17:16];
  // Addressed writes shift out two bytes (0xC0|addr, data); all others one.
  assign last_bit = (op == 2'b01) ? 7'd15 : 7'd7;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    tx_d    = tx_q;
    desc_d  = desc_q;
    rx_d    = rx_q;
    data_d  = data_q;
    valid_d = 1'b0;
    stb_d   = stb_q;
    sclk_d  = sclk_q;
    dio_d   = dio_q;
    oe_d    = oe_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.i_Data_Ready) begin
          desc_d  = bus.i_Data;
          state_d = S_START;
          stb_d   = 1'b0;
          sclk_d  = 1'b1;
          oe_d    = 1'b1;
          bit_d   = '0;
          // Low byte goes out first; first bit is presented during START.
          if (bus.i_Data[17:16] == 2'b01) begin
            tx_d  = {bus.i_Data[7:0], 4'hC, bus.i_Data[11:8]};
            dio_d = bus.i_Data[8];
          end else begin
            tx_d  = {8'h00, bus.i_Data[7:0]};
            dio_d = bus.i_Data[0];
          end
        end
      end
      S_START: begin
        if (cnt_q == C1_M1) begin
          state_d = S_SEND;
          cnt_d   = '0;
          sclk_d  = 1'b0;
        end
      end
      S_SEND: begin
        if (cnt_q == C1_M1) sclk_d = 1'b1;
        if (cnt_q == C2_M1) begin
          cnt_d = '0;
          if (bit_q == last_bit) begin
            if (op == 2'b10) begin
              state_d = S_TURN;
              oe_d    = 1'b0;
            end else begin
              state_d = S_STOP;
              dio_d   = 1'b1;
            end
          end else begin
            // DIO only moves together with the falling CLK edge.
            bit_d  = bit_q + 7'd1;
            dio_d  = tx_q[4'(bit_q[3:0] + 4'd1)];
            sclk_d = 1'b0;
          end
        end
      end
      S_TURN: begin
        if (cnt_q == C4_M1) begin
          state_d = S_RECV;
          cnt_d   = '0;
          sclk_d  = 1'b0;
          bit_d   = '0;
        end
      end
      S_RECV: begin
        if (cnt_q == C1_M1) sclk_d = 1'b1;
        if (cnt_q == C2_M1) begin
          // Sample on the last clock of the high phase.
          cnt_d              = '0;
          rx_d[bit_q[5:0]]   = io_SPI_Dio;
          if (bit_q == 7'd63) begin
            state_d = S_STOP;
            data_d  = rx_d;
            valid_d = 1'b1;
          end else begin
            bit_d  = bit_q + 7'd1;
            sclk_d = 1'b0;
          end
        end
      end
      S_STOP: begin
        if (cnt_q == C1_M1) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          stb_d   = 1'b1;
          oe_d    = 1'b1;
          dio_d   = 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == C2_M1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      desc_q  <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      stb_q   <= 1'b1;
      sclk_q  <= 1'b1;
      dio_q   <= 1'b1;
      oe_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      desc_q  <= desc_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      stb_q   <= stb_d;
      sclk_q  <= sclk_d;
      dio_q   <= dio_d;
      oe_q    <= oe_d;
    end
  end

  assign io_SPI_Dio       = oe_q ? dio_q : 1'bz;
  assign bus.o_Busy       = (state_q != S_IDLE);
  assign bus.o_Data_Valid = valid_q;
  assign bus.o_Data       = data_q;
  assign bus.o_SPI_Stb    = stb_q;
  assign bus.o_SPI_Clk    = sclk_q;
  assign bus.o_Diag_State = state_q;
  assign bus.o_Diag_Data  = desc_q;
  // Address is held for the whole addressed write; byte index only in RECV.
  assign bus.o_Diag_Addr  = (state_q != S_IDLE && op == 2'b01) ? desc_q[11:8] :
                            (state_q == S_RECV) ? {1'b0, bit_q[5:3]} : 4'd0;

endmodule

// File: tb/tb_tm1638_spi.sv
// tb_tm1638_spi: directed, table-driven bench for tm1638_spi (CYCLES=4),
// with hand-written sequences for request filtering and mid-transfer reset.
module tb_tm1638_spi;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tm1638_spi_if bus();
  wire  dio;
  logic tb_oe  = 1'b0;
  logic tb_bit = 1'b0;
  assign dio = tb_oe ? tb_bit : 1'bz;

  tm1638_spi #(.CYCLES(C)) dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .bus        (bus),
    .io_SPI_Dio (dio)
  );

  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [17:0] d;
    logic [63:0] rpat;
    int          busy;
    int          stb;
    int          rises;
    logic [15:0] tx;
    int          ntx;
    int          hi8;
    logic [63:0] dexp;
    int          vexp;
  } vec_t;

  vec_t tbl [8];

  // Issue one descriptor and observe the whole transaction at negedges.
  task automatic run_txn(input logic [17:0] d, input logic [63:0] rpat,
                         output int busy_n, output int stb_n, output int rise_n,
                         output int hi8_n, output int valid_n, output int addr_bad,
                         output int st0, output logic [15:0] txb);
    logic pclk;
    logic rd;
    logic in_hi8;
    int   fall_n;
    int   ea;
    rd = (d[17:16] == 2'b10);
    busy_n = 0; stb_n = 0; rise_n = 0; hi8_n = 0; valid_n = 0; addr_bad = 0;
    fall_n = 0; txb = '0; in_hi8 = 1'b0; pclk = 1'b1; st0 = -1;
    @(negedge clk);
    bus.i_Data = d;
    bus.i_Data_Ready = 1'b1;
    @(negedge clk);
    bus.i_Data_Ready = 1'b0;
    st0 = int'(bus.o_Diag_State);
    for (int n = 0; n < 4000; n++) begin
      if (n > 0) @(negedge clk);
      if (!bus.o_Busy) break;
      busy_n++;
      if (!bus.o_SPI_Stb) stb_n++;
      if (bus.o_Data_Valid) begin
        valid_n++;
        tb_oe = 1'b0;
      end
      if (bus.o_SPI_Clk && !pclk) begin
        rise_n++;
        if (rise_n <= 16) txb[rise_n-1] = dio;
        if (rd) begin
          ea = (rise_n <= 8) ? 0 : ((rise_n - 9) >> 3);
          if (int'(bus.o_Diag_Addr) != ea) addr_bad++;
        end
        if (rise_n == 8) in_hi8 = 1'b1;
      end
      if (!bus.o_SPI_Clk && pclk) begin
        fall_n++;
        in_hi8 = 1'b0;
        if (rd && fall_n >= 9 && fall_n <= 72) begin
          tb_oe  = 1'b1;
          tb_bit = rpat[fall_n-9];
        end
      end
      if (in_hi8 && bus.o_SPI_Clk) hi8_n++;
      if (!rd) begin
        ea = (d[17:16] == 2'b01) ? int'(d[11:8]) : 0;
        if (int'(bus.o_Diag_Addr) != ea) addr_bad++;
      end
      pclk = bus.o_SPI_Clk;
    end
    tb_oe = 1'b0;
  endtask

  initial begin
    int busy_n, stb_n, rise_n, hi8_n, valid_n, addr_bad, st0, run;
    logic [15:0] txb;
    logic [15:0] mask;
    logic [16:0] pat;
    logic [17:0] pd, pdiag;
    logic        pr, pb;

    //            d          rpat                    busy stb  rise tx        ntx hi8 dexp                    v
    tbl[0] = '{18'h00001, 64'h0,                  80,  72,  8,  16'h0001,  8, 16, 64'h0,                  0};
    tbl[1] = '{18'h10505, 64'h0,                  144, 136, 16, 16'h05C5, 16, 4,  64'h0,                  0};
    tbl[2] = '{18'h20042, 64'h0123456789ABCDEF,   608, 600, 72, 16'h0042,  8, 20, 64'h0123456789ABCDEF,   1};
    tbl[3] = '{18'h300A5, 64'h0,                  80,  72,  8,  16'h00A5,  8, 16, 64'h0123456789ABCDEF,   0};
    tbl[4] = '{18'h10F3C, 64'h0,                  144, 136, 16, 16'h3CCF, 16, 4,  64'h0123456789ABCDEF,   0};
    tbl[5] = '{18'h200FF, 64'hFFFF0000A5A55A5A,   608, 600, 72, 16'h00FF,  8, 20, 64'hFFFF0000A5A55A5A,   1};
    tbl[6] = '{18'h0F0C8, 64'h0,                  80,  72,  8,  16'h00C8,  8, 16, 64'hFFFF0000A5A55A5A,   0};
    tbl[7] = '{18'h20000, 64'h8000000000000001,   608, 600, 72, 16'h0000,  8, 20, 64'h8000000000000001,   1};

    bus.i_Data_Ready = 1'b0;
    bus.i_Data = '0;
    #12;
    chk("rst_async_stb", 64'(bus.o_SPI_Stb), 64'd1);
    chk("rst_async_busy", 64'(bus.o_Busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_stb", 64'(bus.o_SPI_Stb), 64'd1);
    chk("idle_clk", 64'(bus.o_SPI_Clk), 64'd1);
    chk("idle_dio", 64'(dio), 64'd1);
    chk("idle_busy", 64'(bus.o_Busy), 64'd0);
    chk("idle_valid", 64'(bus.o_Data_Valid), 64'd0);
    chk("idle_data", bus.o_Data, 64'd0);
    chk("idle_state", 64'(bus.o_Diag_State), 64'd0);
    chk("idle_diag_data", 64'(bus.o_Diag_Data), 64'd0);
    chk("idle_diag_addr", 64'(bus.o_Diag_Addr), 64'd0);

    for (int v = 0; v < 8; v++) begin
      run_txn(tbl[v].d, tbl[v].rpat, busy_n, stb_n, rise_n, hi8_n, valid_n, addr_bad, st0, txb);
      mask = (tbl[v].ntx == 16) ? 16'hFFFF : 16'h00FF;
      chk($sformatf("v%0d_busy_clks", v), 64'(busy_n), 64'(tbl[v].busy));
      chk($sformatf("v%0d_stb_low", v), 64'(stb_n), 64'(tbl[v].stb));
      chk($sformatf("v%0d_clk_pulses", v), 64'(rise_n), 64'(tbl[v].rises));
      chk($sformatf("v%0d_tx_bits", v), 64'(txb & mask), 64'(tbl[v].tx));
      chk($sformatf("v%0d_high_after_8", v), 64'(hi8_n), 64'(tbl[v].hi8));
      chk($sformatf("v%0d_valid_pulses", v), 64'(valid_n), 64'(tbl[v].vexp));
      chk($sformatf("v%0d_rdata", v), bus.o_Data, tbl[v].dexp);
      chk($sformatf("v%0d_diag_data", v), 64'(bus.o_Diag_Data), 64'(tbl[v].d));
      chk($sformatf("v%0d_addr_bad", v), 64'(addr_bad), 64'd0);
      chk($sformatf("v%0d_start_state", v), 64'(st0), 64'd1);
      chk($sformatf("v%0d_end_dio", v), 64'(dio), 64'd1);
    end

    // Requests toggling every other clock: only idle-time requests latch.
    pat = 17'h0B4E7;
    run = 0;
    @(negedge clk);
    for (int cyc = 0; cyc < 240; cyc++) begin
      pat = {pat[15:0], pat[16]};
      bus.i_Data = {1'b0, pat};
      bus.i_Data_Ready = (cyc % 2 == 1);
      pd = bus.i_Data; pr = bus.i_Data_Ready; pb = bus.o_Busy; pdiag = bus.o_Diag_Data;
      @(negedge clk);
      if (pr && !pb) begin
        chk("tog_accept_busy", 64'(bus.o_Busy), 64'd1);
        chk("tog_accept_desc", 64'(bus.o_Diag_Data), 64'(pd));
      end else if (pr) begin
        chk("tog_ignore_desc", 64'(bus.o_Diag_Data), 64'(pdiag));
      end
      if (bus.o_Busy) run++;
      else if (run > 0) begin
        chk("tog_busy_len", 64'(run), (bus.o_Diag_Data[17:16] == 2'b01) ? 64'd144 : 64'd80);
        run = 0;
      end
    end
    bus.i_Data_Ready = 1'b0;
    for (int n = 0; n < 400 && bus.o_Busy; n++) begin
      @(negedge clk);
      if (bus.o_Busy) run++;
      else begin
        chk("tog_busy_len", 64'(run), (bus.o_Diag_Data[17:16] == 2'b01) ? 64'd144 : 64'd80);
        run = 0;
      end
    end
    chk("tog_drained", 64'(bus.o_Busy), 64'd0);

    // Asynchronous reset in the middle of SEND.
    @(negedge clk);
    bus.i_Data = 18'h000FF;
    bus.i_Data_Ready = 1'b1;
    @(negedge clk);
    bus.i_Data_Ready = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_state_send", 64'(bus.o_Diag_State), 64'd2);
    chk("mid_stb_low", 64'(bus.o_SPI_Stb), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_stb", 64'(bus.o_SPI_Stb), 64'd1);
    chk("mid_rst_clk", 64'(bus.o_SPI_Clk), 64'd1);
    chk("mid_rst_dio", 64'(dio), 64'd1);
    chk("mid_rst_busy", 64'(bus.o_Busy), 64'd0);
    chk("mid_rst_state", 64'(bus.o_Diag_State), 64'd0);
    chk("mid_rst_data", bus.o_Data, 64'd0);
    chk("mid_rst_diag_data", 64'(bus.o_Diag_Data), 64'd0);
    chk("mid_rst_diag_addr", 64'(bus.o_Diag_Addr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_txn(18'h00001, 64'h0, busy_n, stb_n, rise_n, hi8_n, valid_n, addr_bad, st0, txb);
    chk("post_rst_busy", 64'(busy_n), 64'd80);
    chk("post_rst_stb", 64'(stb_n), 64'd72);
    chk("post_rst_tx", 64'(txb & 16'h00FF), 64'h01);
    chk("post_rst_desc", 64'(bus.o_Diag_Data), 64'h00001);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
